// File: rtl/fp_mul_pkg.sv
// Shared FP multiply-path definitions: controller states and mantissa widths.
// The FP adder picks up the same width constants.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int SP_MANT_W = 24;
    localparam int DP_MANT_W = 53;

    function automatic int steps_for(input int mant_w, input int digit_bits);
        return mant_w / digit_bits;
    endfunction

endpackage

// File: rtl/mant_mul_step.sv
// One radix-2^DIGIT_BITS shift-add step: acc_next = acc + (a * digit) << (cnt * DIGIT_BITS).
module mant_mul_step #(
    parameter int MANT_W     = 24,
    parameter int DIGIT_BITS = 1,
    parameter int CNT_W      = 5
) (
    input  logic [2*MANT_W-1:0]   acc,
    input  logic [MANT_W-1:0]     a,
    input  logic [DIGIT_BITS-1:0] digit,
    input  logic [CNT_W-1:0]      cnt,
    output logic [2*MANT_W-1:0]   acc_next
);

    localparam int PW = 2 * MANT_W;

    logic [PW-1:0] partial;
    logic [PW-1:0] shifted;
    logic [31:0]   shamt;

    assign partial = {{MANT_W{1'b0}}, a} * {{(PW-DIGIT_BITS){1'b0}}, digit};
    assign shamt   = {{(32-CNT_W){1'b0}}, cnt} * 32'(DIGIT_BITS);
    assign shifted = partial << shamt;

    // The running sum never exceeds (2^W-1)^2, so the dropped carry is always zero.
    ripple_carry #(
        .W(PW)
    ) u_add (
        .x  (acc),
        .y  (shifted),
        .sum(acc_next)
    );

endmodule

// File: rtl/ripple_carry.sv
// Plain ripple-carry adder; any carry out of the top bit is dropped.
module ripple_carry #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry;

    always_comb begin
        carry = '0;
        for (int i = 1; i < W; i++) begin
            carry[i] = (x[i-1] & y[i-1]) | (carry[i-1] & (x[i-1] ^ y[i-1]));
        end
        sum = x ^ y ^ carry;
    end

endmodule

// File: rtl/mantissa_seq_multiplier.sv
// Multi-cycle unsigned mantissa multiplier retiring DIGIT_BITS multiplier bits per cycle,
// with valid/ready on both sides, zero-operand early-out and a normaliser MSB hint.
module mantissa_seq_multiplier
    import fp_mul_pkg::*;
#(
    parameter int MANT_W     = SP_MANT_W,
    parameter int DIGIT_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-1:0]     a,
    input  logic [MANT_W-1:0]     b,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   product,
    output logic                  msb_set,
    output logic                  busy
);

    localparam int STEPS = steps_for(MANT_W, DIGIT_BITS);
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int PW    = 2 * MANT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    if (MANT_W % DIGIT_BITS != 0) begin : g_bad_digit
        $error("mantissa_seq_multiplier: MANT_W must be a multiple of DIGIT_BITS");
    end

    mul_state_t        state;
    mul_state_t        state_next;
    logic [MANT_W-1:0] a_reg;
    logic [MANT_W-1:0] b_reg;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_step;
    logic [CNT_W-1:0]  cnt;
    logic              operand_zero;

    assign operand_zero = (a == '0) || (b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every other transition, including accept and handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = operand_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    mant_mul_step #(
        .MANT_W    (MANT_W),
        .DIGIT_BITS(DIGIT_BITS),
        .CNT_W     (CNT_W)
    ) u_step (
        .acc     (acc),
        .a       (a_reg),
        .digit   (b_reg[DIGIT_BITS-1:0]),
        .cnt     (cnt),
        .acc_next(acc_step)
    );

    // The multiplier register shifts right so the next digit always sits at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc   <= acc_step;
                    b_reg <= b_reg >> DIGIT_BITS;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign product = acc;
    assign msb_set = out_valid & acc[PW-1];

endmodule

// File: tb/tb_mantissa_seq_multiplier.sv
// Bench for mantissa_seq_multiplier: six W=24 instances (D = 1,2,3,4,6,8) share one
// operand bus and are compared against plain a*b arithmetic.
module tb_mantissa_seq_multiplier;

    localparam int W      = 24;
    localparam int ND     = 6;
    localparam int BUDGET = 60;

    function automatic int digit_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 6;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic           msb;
    } vec_t;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           in_valid = 1'b0;
    logic           flush    = 1'b0;
    logic [W-1:0]   a        = '0;
    logic [W-1:0]   b        = '0;
    logic [ND-1:0]  out_ready = '0;
    logic [ND-1:0]  in_ready;
    logic [ND-1:0]  out_valid;
    logic [ND-1:0]  msb_set;
    logic [ND-1:0]  busy;
    logic [2*W-1:0] product [ND];

    int             checks = 0;
    int             errors = 0;
    int             lat [ND];
    logic [2*W-1:0] got_prod [ND];
    logic [ND-1:0]  got_msb;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int D = digit_of(g);
        mantissa_seq_multiplier #(
            .MANT_W    (W),
            .DIGIT_BITS(D)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .a        (a),
            .b        (b),
            .flush    (flush),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .product  (product[g]),
            .msb_set  (msb_set[g]),
            .busy     (busy[g])
        );
    end

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        p = {40'b0, x} * {40'b0, y};
        return p[2*W-1:0];
    endfunction

    // Rising edges counted from the edge that samples in_valid up to the first out_valid.
    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y, input int idx);
        if (x == '0 || y == '0) return 1;
        return W / digit_of(idx) + 1;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issues one op to every instance with out_ready high and collects each result.
    task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [ND-1:0] done;
        done = '0;
        for (int g = 0; g < ND; g++) lat[g] = -1;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = '1;
        for (int e = 1; e <= BUDGET && done != '1; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int g = 0; g < ND; g++) begin
                if (!done[g] && out_valid[g]) begin
                    done[g]     = 1'b1;
                    lat[g]      = e;
                    got_prod[g] = product[g];
                    got_msb[g]  = msb_set[g];
                end
            end
        end
        check_output("op_complete", 64'(done), 64'({ND{1'b1}}));
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_in_ready"}, 64'(in_ready), 64'({ND{1'b1}}));
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check_output({tag, "_busy"}, 64'(busy), 64'(0));
        check_output({tag, "_msb_set"}, 64'(msb_set), 64'(0));
        for (int g = 0; g < ND; g++) begin
            check_output($sformatf("%s_product_d%0d", tag, digit_of(g)), 64'(product[g]), 64'(0));
        end
    endtask

    initial begin
        vec_t           vecs [9];
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] exp_p;
        logic           found;

        vecs[0] = '{24'h800000, 24'h800000, 48'h4000_0000_0000, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 1'b1};
        vecs[2] = '{24'h000000, 24'hC00000, 48'h0000_0000_0000, 1'b0};
        vecs[3] = '{24'hC00000, 24'h000000, 48'h0000_0000_0000, 1'b0};
        vecs[4] = '{24'h000001, 24'h000001, 48'h0000_0000_0001, 1'b0};
        vecs[5] = '{24'hFFFFFF, 24'h000001, 48'h0000_00FF_FFFF, 1'b0};
        vecs[6] = '{24'h800000, 24'hFFFFFF, 48'h7FFF_FF80_0000, 1'b0};
        vecs[7] = '{24'hC00000, 24'hC00000, 48'h9000_0000_0000, 1'b1};
        vecs[8] = '{24'h000003, 24'h000005, 48'h0000_0000_000F, 1'b0};

        #12;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b);
            for (int g = 0; g < ND; g++) begin
                check_output($sformatf("vec%0d_prod_d%0d", i, digit_of(g)), 64'(got_prod[g]), 64'(vecs[i].prod));
                check_output($sformatf("vec%0d_msb_d%0d", i, digit_of(g)), 64'(got_msb[g]), 64'(vecs[i].msb));
                check_output($sformatf("vec%0d_lat_d%0d", i, digit_of(g)), 64'(lat[g]),
                             64'(ref_latency(vecs[i].a, vecs[i].b, g)));
            end
        end

        // Backpressure: results must hold while out_ready is low, even with new operands offered.
        a         = 24'hABCDEF;
        b         = 24'h123457;
        exp_p     = ref_product(24'hABCDEF, 24'h123457);
        out_ready = '0;
        in_valid  = 1'b1;
        found     = 1'b0;
        for (int e = 1; e <= BUDGET && !found; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            found    = out_valid[0];
        end
        check_output("bp_out_valid_seen", 64'(found), 64'(1));
        for (int c = 0; c < 10; c++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            check_output($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'(0));
            check_output($sformatf("bp_hold%0d_out_valid", c), 64'(out_valid), 64'({ND{1'b1}}));
            for (int g = 0; g < ND; g++) begin
                check_output($sformatf("bp_hold%0d_prod_d%0d", c, digit_of(g)), 64'(product[g]), 64'(exp_p));
            end
        end
        in_valid  = 1'b0;
        out_ready = '1;
        @(negedge clk);
        check_output("bp_release_in_ready", 64'(in_ready), 64'({ND{1'b1}}));
        check_output("bp_release_out_valid", 64'(out_valid), 64'(0));

        // Flush beats a simultaneous in_valid in IDLE.
        a        = 24'h400001;
        b        = 24'h300003;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_output("flush_vs_accept_busy", 64'(busy), 64'(0));
        check_output("flush_vs_accept_in_ready", 64'(in_ready), 64'({ND{1'b1}}));

        // Flush in the fifth BUSY cycle of the D=1 instance.
        a        = 24'hFFFFFF;
        b        = 24'hFFFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("flush_pre_busy_d1", 64'(busy[0]), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_output("flush_in_ready", 64'(in_ready), 64'({ND{1'b1}}));
        check_output("flush_out_valid", 64'(out_valid), 64'(0));
        check_output("flush_busy", 64'(busy), 64'(0));
        check_output("flush_msb_set", 64'(msb_set), 64'(0));

        // Asynchronous reset in the middle of a second op, sampled before any clock edge.
        a        = 24'hC00000;
        b        = 24'hC00000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_pre_busy_d1", 64'(busy[0]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 24) == 0) ra = '0;
            if ($urandom_range(0, 24) == 0) rb = '0;
            exp_p = ref_product(ra, rb);
            apply_stimulus(ra, rb);
            for (int g = 0; g < ND; g++) begin
                check_output($sformatf("rand%0d_prod_d%0d a=%0h b=%0h", n, digit_of(g), ra, rb),
                             64'(got_prod[g]), 64'(exp_p));
                check_output($sformatf("rand%0d_msb_d%0d", n, digit_of(g)), 64'(got_msb[g]), 64'(exp_p[2*W-1]));
                check_output($sformatf("rand%0d_lat_d%0d", n, digit_of(g)), 64'(lat[g]),
                             64'(ref_latency(ra, rb, g)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
